// File: rtl/sram_arb_2p.sv
// Two-port round-robin arbiter in front of a single-port SRAM macro with a spare data bit.
// Optionally zero-fills the whole array after reset before accepting requests.
module sram_arb_2p #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 64,
  parameter int NUM_WMASKS = 8,
  parameter int INIT_ZERO  = 1
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  p0_valid,
  output logic                  p0_ready,
  input  logic                  p0_we,
  input  logic [NUM_WMASKS-1:0] p0_wmask,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  output logic                  p0_rvalid,
  output logic [DATA_WIDTH-1:0] p0_rdata,
  input  logic                  p1_valid,
  output logic                  p1_ready,
  input  logic                  p1_we,
  input  logic [NUM_WMASKS-1:0] p1_wmask,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  output logic                  p1_rvalid,
  output logic [DATA_WIDTH-1:0] p1_rdata,
  output logic                  init_done,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic                  sram_spare_wen0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH:0]   sram_din0,
  input  logic [DATA_WIDTH:0]   sram_dout0
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] init_addr;
  logic                  init_last;
  logic                  grant0, grant1, accept;
  logic                  prio_p1;
  logic                  sel_we;
  logic [NUM_WMASKS-1:0] sel_wmask;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  rd_v1, rd_o1, rd_v2, rd_o2;
  logic                  dout_spare_unused;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  assign init_last         = &init_addr;
  assign dout_spare_unused = sram_dout0[DATA_WIDTH];
  assign sram_spare_wen0   = 1'b0;

  always_comb begin
    state_next = state;
    grant0     = 1'b0;
    grant1     = 1'b0;
    case (state)
      ST_INIT: if (init_last) state_next = ST_RUN;
      ST_RUN: begin
        // Ready is combinational, so gate it with reset to keep it low while reset is held.
        if (!wb_rst_i) begin
          if (p0_valid && !(p1_valid && prio_p1)) grant0 = 1'b1;
          else if (p1_valid)                       grant1 = 1'b1;
        end
      end
      default: state_next = ST_RUN;
    endcase
  end

  assign p0_ready  = grant0;
  assign p1_ready  = grant1;
  assign accept    = grant0 | grant1;
  assign sel_we    = grant1 ? p1_we    : p0_we;
  assign sel_wmask = grant1 ? p1_wmask : p0_wmask;
  assign sel_addr  = grant1 ? p1_addr  : p0_addr;
  assign sel_wdata = grant1 ? p1_wdata : p0_wdata;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= (INIT_ZERO != 0) ? ST_INIT : ST_RUN;
    else          state <= state_next;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      init_addr   <= '0;
      init_done   <= 1'b0;
      prio_p1     <= 1'b0;
      sram_csb0   <= 1'b1;
      sram_web0   <= 1'b1;
      sram_wmask0 <= '0;
      sram_addr0  <= '0;
      sram_din0   <= '0;
      rd_v1       <= 1'b0;
      rd_o1       <= 1'b0;
      rd_v2       <= 1'b0;
      rd_o2       <= 1'b0;
      p0_rvalid   <= 1'b0;
      p1_rvalid   <= 1'b0;
      p0_rdata    <= '0;
      p1_rdata    <= '0;
    end else begin
      // Read pipeline: stage 1 = macro sampling, stage 2 = macro output valid.
      rd_v2     <= rd_v1;
      rd_o2     <= rd_o1;
      rd_v1     <= 1'b0;
      p0_rvalid <= rd_v2 && !rd_o2;
      p1_rvalid <= rd_v2 && rd_o2;
      if (rd_v2 && !rd_o2) p0_rdata <= sram_dout0[DATA_WIDTH-1:0];
      if (rd_v2 && rd_o2)  p1_rdata <= sram_dout0[DATA_WIDTH-1:0];
      sram_csb0 <= 1'b1;
      sram_web0 <= 1'b1;
      if (state == ST_INIT) begin
        sram_csb0   <= 1'b0;
        sram_web0   <= 1'b0;
        sram_wmask0 <= '1;
        sram_addr0  <= init_addr;
        sram_din0   <= '0;
        init_addr   <= init_addr + ADDR_ONE;
        if (init_last) init_done <= 1'b1;
      end else begin
        init_done <= 1'b1;
        if (accept) begin
          sram_csb0   <= 1'b0;
          sram_web0   <= ~sel_we;
          sram_wmask0 <= sel_we ? sel_wmask : '0;
          sram_addr0  <= sel_addr;
          sram_din0   <= {1'b0, sel_wdata};
          rd_v1       <= ~sel_we;
          rd_o1       <= grant1;
          prio_p1     <= grant0;
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_arb_2p.sv
// Directed bench for sram_arb_2p with a behavioural SRAM macro model (1-cycle registered read).
// A second instance with INIT_ZERO=0 covers immediate acceptance after reset.
module tb_sram_arb_2p;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_valid, p0_we, p1_valid, p1_we;
  logic [7:0]  p0_wmask, p1_wmask;
  logic [8:0]  p0_addr, p1_addr;
  logic [63:0] p0_wdata, p1_wdata;
  logic        p0_ready, p1_ready, p0_rvalid, p1_rvalid, init_done;
  logic [63:0] p0_rdata, p1_rdata;
  logic        sram_csb0, sram_web0, sram_spare_wen0;
  logic [7:0]  sram_wmask0;
  logic [8:0]  sram_addr0;
  logic [64:0] sram_din0, sram_dout0;

  logic        nz_rst, nz_p0_valid, nz_p0_ready, nz_p1_ready, nz_p0_rvalid, nz_p1_rvalid;
  logic        nz_init_done, nz_csb0, nz_web0, nz_spare_wen0;
  logic [63:0] nz_p0_rdata, nz_p1_rdata;
  logic [7:0]  nz_wmask0;
  logic [8:0]  nz_addr0;
  logic [64:0] nz_din0;
  logic [64:0] nz_dout0 = '0;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [63:0] DATA_A = 64'hA5A5_0000_1234_0020;
  localparam logic [63:0] DATA_B = 64'h5A5A_0000_8765_0021;

  always #5 clk = ~clk;

  sram_arb_2p #(.ADDR_WIDTH(9), .DATA_WIDTH(64), .NUM_WMASKS(8), .INIT_ZERO(1)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_we(p0_we), .p0_wmask(p0_wmask),
    .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_we(p1_we), .p1_wmask(p1_wmask),
    .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .init_done(init_done), .sram_csb0(sram_csb0), .sram_web0(sram_web0),
    .sram_wmask0(sram_wmask0), .sram_spare_wen0(sram_spare_wen0), .sram_addr0(sram_addr0),
    .sram_din0(sram_din0), .sram_dout0(sram_dout0)
  );

  sram_arb_2p #(.ADDR_WIDTH(9), .DATA_WIDTH(64), .NUM_WMASKS(8), .INIT_ZERO(0)) dut_nz (
    .wb_clk_i(clk), .wb_rst_i(nz_rst),
    .p0_valid(nz_p0_valid), .p0_ready(nz_p0_ready), .p0_we(1'b0), .p0_wmask(8'h00),
    .p0_addr(9'd7), .p0_wdata(64'h0), .p0_rvalid(nz_p0_rvalid), .p0_rdata(nz_p0_rdata),
    .p1_valid(1'b0), .p1_ready(nz_p1_ready), .p1_we(1'b0), .p1_wmask(8'h00),
    .p1_addr(9'd0), .p1_wdata(64'h0), .p1_rvalid(nz_p1_rvalid), .p1_rdata(nz_p1_rdata),
    .init_done(nz_init_done), .sram_csb0(nz_csb0), .sram_web0(nz_web0),
    .sram_wmask0(nz_wmask0), .sram_spare_wen0(nz_spare_wen0), .sram_addr0(nz_addr0),
    .sram_din0(nz_din0), .sram_dout0(nz_dout0)
  );

  // Macro model: samples on the rising edge while selected; read data appears after that edge.
  // Spare bit is preset to 1 everywhere and never written, so rdata must ignore it.
  logic [64:0] mem [0:511];
  initial begin
    for (int i = 0; i < 512; i++) mem[i] = {1'b1, 64'hDEAD_BEEF_CAFE_F00D};
    sram_dout0 = '0;
  end
  always @(posedge clk) begin
    if (!sram_csb0) begin
      if (!sram_web0) begin
        for (int b = 0; b < 8; b++)
          if (sram_wmask0[b]) mem[sram_addr0][b*8 +: 8] <= sram_din0[b*8 +: 8];
      end else begin
        sram_dout0 <= mem[sram_addr0];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic p1_write(input logic [8:0] addr, input logic [63:0] data);
    p1_valid = 1'b1; p1_we = 1'b1; p1_addr = addr; p1_wdata = data; p1_wmask = 8'hFF;
    @(negedge clk);
    chk($sformatf("p1_wr_ready_%0d", addr), 64'(p1_ready), 64'd1);
    step();
    p1_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0]  seq_addr [3];
    logic [63:0] seq_data [3];
    rst = 1'b1; nz_rst = 1'b1; nz_p0_valid = 1'b1;
    p0_valid = 1'b1; p0_we = 1'b0; p0_addr = 9'd5; p0_wdata = '0; p0_wmask = '0;
    p1_valid = 1'b0; p1_we = 1'b0; p1_addr = '0;   p1_wdata = '0; p1_wmask = '0;

    // Reset state of both instances.
    step(); step();
    @(negedge clk);
    chk("rst_csb0", 64'(sram_csb0), 64'd1);
    chk("rst_web0", 64'(sram_web0), 64'd1);
    chk("rst_wmask0", 64'(sram_wmask0), 64'd0);
    chk("rst_init_done", 64'(init_done), 64'd0);
    chk("rst_p0_ready", 64'(p0_ready), 64'd0);
    chk("rst_p0_rvalid", 64'(p0_rvalid), 64'd0);
    chk("rst_p0_rdata", p0_rdata, 64'd0);
    chk("nz_rst_ready", 64'(nz_p0_ready), 64'd0);
    chk("nz_rst_init_done", 64'(nz_init_done), 64'd0);

    // INIT_ZERO=0: accepted in the first cycle after reset.
    step();
    nz_rst = 1'b0;
    @(negedge clk);
    chk("nz_ready_first", 64'(nz_p0_ready), 64'd1);
    step();
    chk("nz_init_done", 64'(nz_init_done), 64'd1);
    chk("nz_csb0", 64'(nz_csb0), 64'd0);
    chk("nz_addr0", 64'(nz_addr0), 64'd7);
    nz_p0_valid = 1'b0;

    // Zero-fill: one write per cycle, 0..511, init_done with the last one.
    rst = 1'b0;
    for (int i = 0; i < 512; i++) begin
      @(negedge clk);
      chk($sformatf("init_ready_%0d", i), 64'(p0_ready), 64'd0);
      step();
      chk($sformatf("init_addr_%0d", i), 64'(sram_addr0), 64'(i));
      chk($sformatf("init_we_%0d", i), 64'({sram_csb0, sram_web0, sram_wmask0}), 64'h0FF);
      chk($sformatf("init_din_%0d", i), sram_din0[63:0], 64'd0);
      chk($sformatf("init_done_%0d", i), 64'(init_done), (i == 511) ? 64'd1 : 64'd0);
    end

    // Read of addr 5 after zero-fill returns 0.
    @(negedge clk);
    chk("rd5_ready", 64'(p0_ready), 64'd1);
    step();
    p0_valid = 1'b0;
    chk("rd5_macro", 64'({sram_csb0, sram_web0, sram_wmask0, sram_addr0}), {47'd0, 1'b0, 1'b1, 8'h00, 9'd5});
    step();
    chk("rd5_rvalid_e1", 64'(p0_rvalid), 64'd0);
    step();
    chk("rd5_rvalid_e2", 64'(p0_rvalid), 64'd1);
    chk("rd5_rdata", p0_rdata, 64'd0);
    step();
    chk("rd5_rvalid_drop", 64'(p0_rvalid), 64'd0);

    // Masked write then immediate read of the same address.
    p0_valid = 1'b1; p0_we = 1'b1; p0_addr = 9'd3; p0_wdata = 64'h1122334455667788; p0_wmask = 8'h0F;
    @(negedge clk);
    chk("wr3_ready", 64'(p0_ready), 64'd1);
    step();
    chk("wr3_macro", 64'({sram_csb0, sram_web0, sram_wmask0}), 64'h00F);
    chk("wr3_din", sram_din0[63:0], 64'h1122334455667788);
    chk("wr3_spare", 64'({sram_din0[64], sram_spare_wen0}), 64'd0);
    p0_we = 1'b0;
    @(negedge clk);
    chk("rd3_ready", 64'(p0_ready), 64'd1);
    step();
    p0_valid = 1'b0;
    chk("rd3_wmask0", 64'(sram_wmask0), 64'd0);
    step();
    chk("rd3_rvalid_e1", 64'(p0_rvalid), 64'd0);
    step();
    chk("rd3_rvalid", 64'({p0_rvalid, p1_rvalid}), 64'b10);
    chk("rd3_rdata", p0_rdata, 64'h0000000055667788);
    step();
    chk("idle_csb0", 64'({sram_csb0, sram_web0}), 64'b11);

    // Preload via p1 so p0 holds priority, then contend for 4 cycles.
    p1_write(9'd20, DATA_A);
    p1_write(9'd21, DATA_B);
    p0_valid = 1'b1; p0_we = 1'b0; p0_addr = 9'd20;
    p1_valid = 1'b1; p1_we = 1'b0; p1_addr = 9'd21;
    for (int s = 1; s <= 6; s++) begin
      if (s <= 4) begin
        @(negedge clk);
        chk($sformatf("rr_ready_%0d", s), 64'({p0_ready, p1_ready}), (s % 2 == 1) ? 64'b10 : 64'b01);
      end
      step();
      if (s == 4) begin p0_valid = 1'b0; p1_valid = 1'b0; end
      chk($sformatf("rr_rvalid_%0d", s), 64'({p0_rvalid, p1_rvalid}),
          (s == 3 || s == 5) ? 64'b10 : (s == 4 || s == 6) ? 64'b01 : 64'b00);
      if (s == 3 || s == 5) chk($sformatf("rr_p0_rdata_%0d", s), p0_rdata, DATA_A);
      if (s == 4 || s == 6) chk($sformatf("rr_p1_rdata_%0d", s), p1_rdata, DATA_B);
    end

    // p1 alone for 3 cycles: back-to-back grants and responses.
    seq_addr[0] = 9'd3;  seq_data[0] = 64'h0000000055667788;
    seq_addr[1] = 9'd20; seq_data[1] = DATA_A;
    seq_addr[2] = 9'd21; seq_data[2] = DATA_B;
    p1_valid = 1'b1; p1_we = 1'b0;
    for (int s = 1; s <= 5; s++) begin
      if (s <= 3) begin
        p1_addr = seq_addr[s-1];
        @(negedge clk);
        chk($sformatf("p1only_ready_%0d", s), 64'({p0_ready, p1_ready}), 64'b01);
      end
      step();
      if (s == 3) p1_valid = 1'b0;
      chk($sformatf("p1only_rvalid_%0d", s), 64'({p0_rvalid, p1_rvalid}), (s >= 3) ? 64'b01 : 64'b00);
      if (s >= 3) chk($sformatf("p1only_rdata_%0d", s), p1_rdata, seq_data[s-3]);
    end
    chk("p0_rdata_held", p0_rdata, DATA_A);

    // Reset one cycle after a read accept drops the read and restarts INIT.
    p0_valid = 1'b1; p0_we = 1'b0; p0_addr = 9'd21;
    @(negedge clk);
    chk("rstmid_ready", 64'(p0_ready), 64'd1);
    step();
    step();
    rst = 1'b1;
    #1;
    chk("rstmid_csb0", 64'({sram_csb0, sram_web0}), 64'b11);
    chk("rstmid_state", 64'({p0_ready, p0_rvalid, init_done}), 64'd0);
    chk("rstmid_rdata", p0_rdata, 64'd0);
    for (int k = 0; k < 2; k++) begin
      step();
      chk($sformatf("rstmid_hold_%0d", k), 64'({sram_csb0, p0_rvalid, p1_rvalid, p0_ready}), 64'b1000);
    end
    rst = 1'b0;
    p0_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      chk($sformatf("reinit_addr_%0d", k), 64'(sram_addr0), 64'(k));
      chk($sformatf("reinit_we_%0d", k), 64'({sram_csb0, sram_web0, init_done, p0_rvalid}), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
